dmem_lsu: RTL

Load/store unit between the execute stage and data memory. It takes one RV32I load/store request at a time, drives the data-memory request/grant/rvalid bus with word-aligned address, byte enables and lane-replicated store data, and returns aligned, sign/zero-extended load data plus destination register toward write-back. It also detects misaligned accesses, illegal funct3 and bus timeouts, and reports each as a registered error event.

---
 rtl/dmem_lsu.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// RV32I load/store unit: one request at a time onto a req/gnt/rvalid data-memory bus.
// Misaligned accesses, illegal funct3 and bus timeouts are reported as registered error pulses.
module dmem_lsu #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_W     = 5,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [XLEN-1:0]       req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  input  logic [REG_ADDR_W-1:0] req_rd,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [XLEN-1:0]       mem_addr,
  output logic [3:0]            mem_be,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  load_valid,
  output logic [XLEN-1:0]       load_data,
  output logic [REG_ADDR_W-1:0] load_rd,
  output logic                  store_done,
  output logic                  err_valid,
  output logic [1:0]            err_cause,
  output logic [XLEN-1:0]       err_addr,
  output logic                  busy
);

  // One spare bit so the count cannot wrap while a granted load sits in WAIT.
  localparam int unsigned CNT_W = 9;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  lat_store_q, lat_store_d;
  logic [2:0]            lat_funct3_q, lat_funct3_d;
  logic [XLEN-1:0]       lat_addr_q, lat_addr_d;
  logic [REG_ADDR_W-1:0] lat_rd_q, lat_rd_d;
  logic                  req_ready_q, req_ready_d;
  logic                  busy_q, busy_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [XLEN-1:0]       mem_addr_q, mem_addr_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [XLEN-1:0]       mem_wdata_q, mem_wdata_d;
  logic                  load_valid_q, load_valid_d;
  logic [XLEN-1:0]       load_data_q, load_data_d;
  logic [REG_ADDR_W-1:0] load_rd_q, load_rd_d;
  logic                  store_done_q, store_done_d;
  logic                  err_valid_q, err_valid_d;
  logic [1:0]            err_cause_q, err_cause_d;
  logic [XLEN-1:0]       err_addr_q, err_addr_d;

  logic                  illegal_c;
  logic                  misaligned_c;
  logic [3:0]            be_c;
  logic [XLEN-1:0]       wdata_c;
  logic [7:0]            rd_byte_c;
  logic [15:0]           rd_half_c;
  logic [XLEN-1:0]       ext_c;
  logic [CNT_W-1:0]      cnt_inc_c;
  logic                  timeout_c;

  // Incoming request decode: legality, alignment, byte lanes and replicated store data.
  always_comb begin
    illegal_c    = (req_funct3[1:0] == 2'b11) | (req_funct3[2] & (req_is_store | req_funct3[1]));
    misaligned_c = 1'b0;
    be_c         = 4'b1111;
    wdata_c      = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << req_addr[1:0];
        wdata_c = XLEN'({4{req_wdata[7:0]}});
      end
      2'b01: begin
        misaligned_c = req_addr[0];
        be_c         = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c      = XLEN'({2{req_wdata[15:0]}});
      end
      2'b10:   misaligned_c = |req_addr[1:0];
      default: ;
    endcase
  end

  // Load data lane select and extension, driven by the latched request.
  always_comb begin
    rd_byte_c = mem_rdata[{lat_addr_q[1:0], 3'b000} +: 8];
    rd_half_c = mem_rdata[{lat_addr_q[1], 4'b0000} +: 16];
    case (lat_funct3_q)
      3'b000:  ext_c = {{(XLEN-8){rd_byte_c[7]}}, rd_byte_c};
      3'b100:  ext_c = {{(XLEN-8){1'b0}}, rd_byte_c};
      3'b001:  ext_c = {{(XLEN-16){rd_half_c[15]}}, rd_half_c};
      3'b101:  ext_c = {{(XLEN-16){1'b0}}, rd_half_c};
      default: ext_c = mem_rdata;
    endcase
  end

  assign cnt_inc_c = cnt_q + CNT_W'(1);
  assign timeout_c = (cnt_inc_c >= CNT_W'(TIMEOUT_CYCLES));

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_store_d  = lat_store_q;
    lat_funct3_d = lat_funct3_q;
    lat_addr_d   = lat_addr_q;
    lat_rd_d     = lat_rd_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    load_data_d  = load_data_q;
    load_rd_d    = load_rd_q;
    err_cause_d  = err_cause_q;
    err_addr_d   = err_addr_q;
    store_done_d = 1'b0;
    err_valid_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          if (illegal_c) begin
            err_valid_d = 1'b1;
            err_cause_d = CAUSE_ILLEGAL;
            err_addr_d  = req_addr;
          end else if (misaligned_c) begin
            err_valid_d = 1'b1;
            err_cause_d = CAUSE_MISALIGN;
            err_addr_d  = req_addr;
          end else begin
            state_d      = S_REQ;
            cnt_d        = '0;
            lat_store_d  = req_is_store;
            lat_funct3_d = req_funct3;
            lat_addr_d   = req_addr;
            lat_rd_d     = req_rd;
            mem_we_d     = req_is_store;
            mem_addr_d   = {req_addr[XLEN-1:2], 2'b00};
            mem_be_d     = be_c;
            mem_wdata_d  = wdata_c;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc_c;
        // A grant in the timeout cycle still completes the request.
        if (mem_gnt) begin
          if (lat_store_q) begin
            store_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end else if (timeout_c) begin
          err_valid_d = 1'b1;
          err_cause_d = CAUSE_TIMEOUT;
          err_addr_d  = lat_addr_q;
          state_d     = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc_c;
        if (mem_rvalid) begin
          load_data_d = ext_c;
          load_rd_d   = lat_rd_q;
          state_d     = S_RESP;
        end else if (timeout_c) begin
          err_valid_d = 1'b1;
          err_cause_d = CAUSE_TIMEOUT;
          err_addr_d  = lat_addr_q;
          state_d     = S_IDLE;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mem_req_d    = (state_d == S_REQ);
    load_valid_d = (state_d == S_RESP);
    req_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lat_store_q  <= 1'b0;
      lat_funct3_q <= '0;
      lat_addr_q   <= '0;
      lat_rd_q     <= '0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      load_rd_q    <= '0;
      store_done_q <= 1'b0;
      err_valid_q  <= 1'b0;
      err_cause_q  <= '0;
      err_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lat_store_q  <= lat_store_d;
      lat_funct3_q <= lat_funct3_d;
      lat_addr_q   <= lat_addr_d;
      lat_rd_q     <= lat_rd_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      load_valid_q <= load_valid_d;
      load_data_q  <= load_data_d;
      load_rd_q    <= load_rd_d;
      store_done_q <= store_done_d;
      err_valid_q  <= err_valid_d;
      err_cause_q  <= err_cause_d;
      err_addr_q   <= err_addr_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign load_valid = load_valid_q;
  assign load_data  = load_data_q;
  assign load_rd    = load_rd_q;
  assign store_done = store_done_q;
  assign err_valid  = err_valid_q;
  assign err_cause  = err_cause_q;
  assign err_addr   = err_addr_q;

endmodule
